// File: rtl/radar_pkg.sv
// radar_pkg: state encoding, default prescale and the configuration legality check
// shared by the radar signal generator.
package radar_pkg;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    localparam int CLK_PER_US_DEF = 100;
    localparam int CFG_W = 64;

    // Callers zero-extend their DATA_WIDTH fields to CFG_W.
    function automatic logic cfg_legal(input logic [CFG_W-1:0] arp_us,
                                       input logic [CFG_W-1:0] acp_cnt,
                                       input logic [CFG_W-1:0] trig_us);
        return (arp_us != '0) && (trig_us != '0) && (acp_cnt != '0) && (acp_cnt <= arp_us);
    endfunction
endpackage

// File: rtl/pulse_stretch.sv
// pulse_stretch: PULSE_CLKS-wide high pulse starting the cycle after fire;
// clear truncates a pulse in progress.
module pulse_stretch #(
    parameter int PULSE_CLKS = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic fire,
    input  logic clear,
    output logic pulse
);
    localparam int CW = $clog2(PULSE_CLKS + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = clear ? '0 : fire ? CW'(PULSE_CLKS) : (cnt_q != '0) ? cnt_q - CW'(1) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pulse = cnt_q != '0;
endmodule

// File: rtl/radar_signal_generator.sv
// radar_signal_generator: synthesises ARP/ACP/TRIG antenna pulses from programmed
// periods so the receive path can be exercised without a physical radar.
module radar_signal_generator
    import radar_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CLK_PER_US = CLK_PER_US_DEF,
    parameter int PULSE_CLKS = 20
) (
    input  logic                  S_AXIS_ACLK,
    input  logic                  S_AXIS_ARESET,
    input  logic                  ENABLE,
    input  logic [DATA_WIDTH-1:0] CFG_ARP_US,
    input  logic [DATA_WIDTH-1:0] CFG_ACP_CNT,
    input  logic [DATA_WIDTH-1:0] CFG_TRIG_US,
    output logic                  ARP,
    output logic                  ACP,
    output logic                  TRIG,
    output logic                  RUNNING,
    output logic                  CFG_ERR,
    output logic [DATA_WIDTH-1:0] ROT_CNT
);
    localparam int DW = DATA_WIDTH;
    localparam int PW = $clog2(CLK_PER_US);

    logic [0:0]    state_q;
    logic [0:0]    state_d;
    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;
    logic [DW-1:0] rot_q;
    logic [DW-1:0] rot_d;
    logic [DW-1:0] arp_p_q;
    logic [DW-1:0] arp_p_d;
    logic [DW-1:0] acp_n_q;
    logic [DW-1:0] acp_n_d;
    logic [DW-1:0] trig_p_q;
    logic [DW-1:0] trig_p_d;
    logic [DW-1:0] trig_cur_q;
    logic [DW-1:0] trig_cur_d;
    logic [DW-1:0] trig_cnt_q;
    logic [DW-1:0] trig_cnt_d;
    logic [DW-1:0] rot_cnt_q;
    logic [DW-1:0] rot_cnt_d;
    logic [DW:0]   acc_q;
    logic [DW:0]   acc_d;
    logic [DW:0]   acc_sum;
    logic          cfg_err_q;
    logic          cfg_err_d;
    logic          legal;
    logic          tick;
    logic          stop;
    logic          arp_fire;
    logic          acp_fire;
    logic          trig_fire;

    assign legal = cfg_legal(CFG_W'(CFG_ARP_US), CFG_W'(CFG_ACP_CNT), CFG_W'(CFG_TRIG_US));
    assign tick  = (state_q == RUN) && (pre_q == PW'(CLK_PER_US - 1));
    assign stop  = (state_q == RUN) && !ENABLE;

    always_comb begin
        state_d    = state_q;
        pre_d      = pre_q;
        rot_d      = rot_q;
        acc_d      = acc_q;
        arp_p_d    = arp_p_q;
        acp_n_d    = acp_n_q;
        trig_p_d   = trig_p_q;
        trig_cur_d = trig_cur_q;
        trig_cnt_d = trig_cnt_q;
        rot_cnt_d  = rot_cnt_q;
        cfg_err_d  = cfg_err_q;
        arp_fire   = 1'b0;
        acp_fire   = 1'b0;
        trig_fire  = 1'b0;
        acc_sum    = acc_q + {1'b0, acp_n_q};
        if (state_q == IDLE) begin
            cfg_err_d = ENABLE && !legal;
            if (ENABLE && legal) begin
                state_d    = RUN;
                pre_d      = '0;
                rot_d      = '0;
                acc_d      = '0;
                trig_cnt_d = '0;
                rot_cnt_d  = '0;
                arp_p_d    = CFG_ARP_US;
                acp_n_d    = CFG_ACP_CNT;
                trig_p_d   = CFG_TRIG_US;
                trig_cur_d = CFG_TRIG_US;
                arp_fire   = 1'b1;
                acp_fire   = 1'b1;
                trig_fire  = 1'b1;
            end
        end else if (!ENABLE) begin
            state_d   = IDLE;
            cfg_err_d = 1'b0;
        end else begin
            pre_d = tick ? '0 : pre_q + PW'(1);
            if (tick) begin
                // Rotation boundary: shadows reload only here, so mid-rotation edits wait for ARP.
                if (rot_q == arp_p_q - DW'(1)) begin
                    rot_d     = '0;
                    acc_d     = '0;
                    arp_fire  = 1'b1;
                    acp_fire  = 1'b1;
                    rot_cnt_d = rot_cnt_q + DW'(1);
                    cfg_err_d = !legal;
                    if (legal) begin
                        arp_p_d  = CFG_ARP_US;
                        acp_n_d  = CFG_ACP_CNT;
                        trig_p_d = CFG_TRIG_US;
                    end
                end else begin
                    rot_d    = rot_q + DW'(1);
                    acp_fire = acc_sum >= {1'b0, arp_p_q};
                    acc_d    = acp_fire ? acc_sum - {1'b0, arp_p_q} : acc_sum;
                end
                trig_fire  = trig_cnt_q == trig_cur_q - DW'(1);
                trig_cnt_d = trig_fire ? '0 : trig_cnt_q + DW'(1);
                trig_cur_d = trig_fire ? trig_p_d : trig_cur_q;
            end
        end
    end

    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET) begin
            state_q    <= IDLE;
            pre_q      <= '0;
            rot_q      <= '0;
            acc_q      <= '0;
            arp_p_q    <= '0;
            acp_n_q    <= '0;
            trig_p_q   <= '0;
            trig_cur_q <= '0;
            trig_cnt_q <= '0;
            rot_cnt_q  <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            rot_q      <= rot_d;
            acc_q      <= acc_d;
            arp_p_q    <= arp_p_d;
            acp_n_q    <= acp_n_d;
            trig_p_q   <= trig_p_d;
            trig_cur_q <= trig_cur_d;
            trig_cnt_q <= trig_cnt_d;
            rot_cnt_q  <= rot_cnt_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    pulse_stretch #(.PULSE_CLKS(PULSE_CLKS)) u_arp (
        .clk(S_AXIS_ACLK), .rst(S_AXIS_ARESET), .fire(arp_fire), .clear(stop), .pulse(ARP)
    );
    pulse_stretch #(.PULSE_CLKS(PULSE_CLKS)) u_acp (
        .clk(S_AXIS_ACLK), .rst(S_AXIS_ARESET), .fire(acp_fire), .clear(stop), .pulse(ACP)
    );
    pulse_stretch #(.PULSE_CLKS(PULSE_CLKS)) u_trig (
        .clk(S_AXIS_ACLK), .rst(S_AXIS_ARESET), .fire(trig_fire), .clear(stop), .pulse(TRIG)
    );

    assign RUNNING = state_q == RUN;
    assign CFG_ERR = cfg_err_q;
    assign ROT_CNT = rot_cnt_q;
endmodule

// File: tb/tb_radar_signal_generator.sv
// tb_radar_signal_generator: event-time reference model checked every cycle, plus
// directed literal checks of pulse spacing, illegal config, abort and async reset.
module tb_radar_signal_generator;
    localparam int DW  = 32;
    localparam int CPU = 4;
    localparam int PC  = 2;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          en      = 1'b0;
    logic [DW-1:0] arp_us  = '0;
    logic [DW-1:0] acp_cnt = '0;
    logic [DW-1:0] trig_us = '0;
    logic          arp;
    logic          acp;
    logic          trig;
    logic          running;
    logic          cfg_err;
    logic [DW-1:0] rot_cnt;

    int errors = 0;
    int checks = 0;

    longint g = 0, e = 0, rs = 0, t = 0, k = 0;
    longint m_arp = 0, m_n = 0, m_trig = 0, next_trig = 0, m_rot = 0;
    longint lf_arp = -100, lf_acp = -100, lf_trig = -100;
    bit     m_run = 0, m_err = 0, m_legal = 0;
    longint cyc = 0;
    logic   p_arp = 0, p_acp = 0, p_trig = 0;
    longint arp_r[$], acp_r[$], trig_r[$];

    radar_signal_generator #(.DATA_WIDTH(DW), .CLK_PER_US(CPU), .PULSE_CLKS(PC)) dut (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst), .ENABLE(en),
        .CFG_ARP_US(arp_us), .CFG_ACP_CNT(acp_cnt), .CFG_TRIG_US(trig_us),
        .ARP(arp), .ACP(acp), .TRIG(trig), .RUNNING(running), .CFG_ERR(cfg_err), .ROT_CNT(rot_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint qat(input longint q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // Reference model: outputs follow from tick index within rotation and fire times.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_run = 0; m_err = 0; m_rot = 0;
            lf_arp = -100; lf_acp = -100; lf_trig = -100;
        end else begin
            g++;
            m_legal = arp_us != 0 && trig_us != 0 && acp_cnt != 0 && acp_cnt <= arp_us;
            if (!m_run) begin
                m_err = en && !m_legal;
                if (en && m_legal) begin
                    m_run = 1; e = 0; rs = 0; m_rot = 0;
                    m_arp = longint'(arp_us); m_n = longint'(acp_cnt); m_trig = longint'(trig_us);
                    next_trig = m_trig;
                    lf_arp = g; lf_acp = g; lf_trig = g;
                end
            end else if (!en) begin
                m_run = 0; m_err = 0;
                lf_arp = -100; lf_acp = -100; lf_trig = -100;
            end else begin
                e++;
                if (e % CPU == 0) begin
                    t = e / CPU;
                    k = t - rs;
                    if (k == m_arp) begin
                        rs = t; lf_arp = g; lf_acp = g; m_rot++;
                        m_err = !m_legal;
                        if (m_legal) begin
                            m_arp = longint'(arp_us); m_n = longint'(acp_cnt); m_trig = longint'(trig_us);
                        end
                    end else if ((k * m_n) / m_arp != ((k - 1) * m_n) / m_arp) begin
                        lf_acp = g;
                    end
                    if (t == next_trig) begin
                        lf_trig = g;
                        next_trig = t + m_trig;
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("ARP", longint'(arp), longint'((g - lf_arp) < PC));
            chk("ACP", longint'(acp), longint'((g - lf_acp) < PC));
            chk("TRIG", longint'(trig), longint'((g - lf_trig) < PC));
            chk("RUNNING", longint'(running), longint'(m_run));
            chk("CFG_ERR", longint'(cfg_err), longint'(m_err));
            chk("ROT_CNT", longint'(rot_cnt), m_rot);
        end
    end

    initial forever begin
        @(negedge clk);
        cyc++;
        if (arp && !p_arp) arp_r.push_back(cyc);
        if (acp && !p_acp) acp_r.push_back(cyc);
        if (trig && !p_trig) trig_r.push_back(cyc);
        p_arp = arp; p_acp = acp; p_trig = trig;
    end

    task automatic restart(input int a, input int n, input int tr);
        en = 0;
        repeat (2) @(negedge clk);
        arp_r.delete(); acp_r.delete(); trig_r.delete();
        arp_us = DW'(a); acp_cnt = DW'(n); trig_us = DW'(tr);
        en = 1;
        @(negedge clk);
    endtask

    task automatic rand_cfg();
        arp_us  = $urandom_range(1, 12);
        acp_cnt = $urandom_range(1, arp_us);
        trig_us = $urandom_range(1, 6);
        if ($urandom_range(0, 7) == 0) acp_cnt = arp_us + 1;
        if ($urandom_range(0, 9) == 0) trig_us = 0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_arp", longint'(arp), 0);
        chk("rst_running", longint'(running), 0);
        chk("rst_rot", longint'(rot_cnt), 0);
        rst = 0;
        @(negedge clk);

        restart(20, 4, 3);
        chk("start_arp", longint'(arp), 1);
        chk("start_acp", longint'(acp), 1);
        chk("start_trig", longint'(trig), 1);
        chk("start_running", longint'(running), 1);
        repeat (239) @(negedge clk);
        #1;
        chk("basic_arp_n", arp_r.size(), 3);
        chk("basic_acp_n", acp_r.size(), 12);
        chk("basic_trig_n", trig_r.size(), 20);
        chk("basic_arp_per", qat(arp_r, 1) - qat(arp_r, 0), 80);
        chk("basic_acp_3", qat(acp_r, 3) - qat(acp_r, 0), 60);
        chk("basic_trig_per", qat(trig_r, 1) - qat(trig_r, 0), 12);
        chk("basic_rot", longint'(rot_cnt), 2);

        restart(10, 3, 7);
        repeat (199) @(negedge clk);
        #1;
        chk("frac_acp_n", acp_r.size(), 15);
        chk("frac_acp_1", qat(acp_r, 1) - qat(acp_r, 0), 16);
        chk("frac_acp_2", qat(acp_r, 2) - qat(acp_r, 0), 28);
        chk("frac_acp_3", qat(acp_r, 3) - qat(acp_r, 0), 40);
        chk("frac_arp_n", arp_r.size(), 5);

        restart(8, 8, 5);
        repeat (63) @(negedge clk);
        #1;
        chk("full_acp_n", acp_r.size(), 16);
        chk("full_acp_per", qat(acp_r, 1) - qat(acp_r, 0), 4);

        en = 0;
        repeat (2) @(negedge clk);
        arp_us = 10; acp_cnt = 11; trig_us = 3; en = 1;
        repeat (3) @(negedge clk);
        chk("ill_err", longint'(cfg_err), 1);
        chk("ill_running", longint'(running), 0);
        chk("ill_arp", longint'(arp), 0);
        chk("ill_trig", longint'(trig), 0);
        acp_cnt = 5;
        @(negedge clk);
        chk("fix_running", longint'(running), 1);
        chk("fix_err", longint'(cfg_err), 0);

        restart(20, 4, 3);
        repeat (28) @(negedge clk);
        arp_us = 16;
        repeat (192) @(negedge clk);
        #1;
        chk("mid_arp_n", arp_r.size(), 4);
        chk("mid_per0", qat(arp_r, 1) - qat(arp_r, 0), 80);
        chk("mid_per1", qat(arp_r, 2) - qat(arp_r, 1), 64);
        chk("mid_per2", qat(arp_r, 3) - qat(arp_r, 2), 64);
        chk("mid_rot", longint'(rot_cnt), 3);

        restart(20, 4, 3);
        repeat (80) @(negedge clk);
        chk("abort_arp_hi", longint'(arp), 1);
        en = 0;
        @(negedge clk);
        chk("abort_arp", longint'(arp), 0);
        chk("abort_running", longint'(running), 0);
        chk("abort_rot_hold", longint'(rot_cnt), 1);

        restart(20, 4, 3);
        repeat (80) @(negedge clk);
        chk("pre_rst_rot", longint'(rot_cnt), 1);
        #2 rst = 1;
        #1;
        chk("arst_arp", longint'(arp), 0);
        chk("arst_acp", longint'(acp), 0);
        chk("arst_trig", longint'(trig), 0);
        chk("arst_running", longint'(running), 0);
        chk("arst_rot", longint'(rot_cnt), 0);
        en = 0;
        repeat (2) @(negedge clk);
        rst = 0;

        for (int s = 0; s < 25; s++) begin
            rand_cfg();
            en = 1;
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                if ($urandom_range(0, 99) < 2) en = !en;
                else if ($urandom_range(0, 99) < 3) rand_cfg();
            end
        end
        en = 0;
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/radar_signal_generator.md
Name: radar_signal_generator

Overview:
- Synthesises the radar antenna interface signals ARP, ACP and TRIG from programmed periods.
- It is the transmit-side counterpart of radar_statistics: a loopback of its outputs into radar_statistics must read back exactly the programmed ARP_US, ACP_CNT and TRIG_US.
- Used for self-test and bench operation when no physical radar is attached.
- Sits in the PL on the AXI clock domain; configuration comes from AXI-Lite registers.

Parameters:
- DATA_WIDTH, 32, width of the period and count configuration inputs and of the rotation counter.
- CLK_PER_US, 100, S_AXIS_ACLK cycles per microsecond tick; must be at least 2.
- PULSE_CLKS, 20, high time of each output pulse in clocks; legal range 1..CLK_PER_US-1.

Ports:
- S_AXIS_ACLK  in  1  system clock.
- S_AXIS_ARESET  in  1  reset, asynchronous, active-high.
- ENABLE  in  1  run request, level-sensitive.
- CFG_ARP_US  in  DATA_WIDTH  rotation period in µs.
- CFG_ACP_CNT  in  DATA_WIDTH  ACP pulses per rotation.
- CFG_TRIG_US  in  DATA_WIDTH  trigger period in µs.
- ARP  out  1  north pulse, once per rotation.
- ACP  out  1  azimuth encoder pulse.
- TRIG  out  1  transmit trigger pulse.
- RUNNING  out  1  high while in RUN.
- CFG_ERR  out  1  high while ENABLE is high and the configuration is illegal.
- ROT_CNT  out  DATA_WIDTH  completed rotations since entering RUN.

Behaviour:
- Reset, asynchronous: ARP, ACP, TRIG, RUNNING, CFG_ERR = 0 and ROT_CNT = 0. All counters, the accumulator and the shadow registers clear; state goes to IDLE.
- Configuration is legal when CFG_ARP_US > 0, CFG_TRIG_US > 0 and 0 < CFG_ACP_CNT <= CFG_ARP_US.

State machine, states IDLE and RUN:
- IDLE → RUN: ENABLE high and configuration legal, sampled on a clock edge.
  - On that edge the shadow registers (arp_p, acp_n, trig_p) load.
  - The µs prescaler, rotation counter, TRIG counter and ACP accumulator clear.
  - ARP, ACP and TRIG all assert on the same edge, i.e. one cycle after ENABLE is sampled high.
- IDLE, ENABLE high with illegal configuration: CFG_ERR = 1 (registered) and the block stays in IDLE.
- RUN → IDLE: ENABLE low, sampled on a clock edge.
  - ARP, ACP, TRIG and RUNNING are 0 on the next cycle.
  - Any pulse in progress is truncated.
  - ROT_CNT holds its value until the next IDLE → RUN, which clears it.

Tick and period rules:
- µs tick: the prescaler counts 0..CLK_PER_US-1; tick is the cycle where it equals CLK_PER_US-1.
- Rotation counter r, width DATA_WIDTH:
  - Increments on each tick.
  - On the tick where r == arp_p-1: r goes to 0, ARP fires, ACP is forced to fire, the accumulator clears, ROT_CNT increments, and all shadow registers reload from the CFG inputs.
  - A configuration change mid-rotation therefore takes effect only at the next ARP.
  - If the new configuration is illegal at that boundary, the old shadow values are kept and CFG_ERR is raised; CFG_ERR clears at the first boundary where the configuration is legal again.
- ACP spacing uses a Bresenham accumulator of width DATA_WIDTH+1, so no divider is needed:
  - On each non-boundary tick: s = acc + acp_n.
  - If s >= arp_p, ACP fires and acc = s - arp_p; otherwise acc = s.
  - Result: exactly acp_n ACPs per rotation, ACP k placed at the tick equal to ceil(k·arp_p/acp_n).
- TRIG counter: free-running modulo trig_p in ticks, independent of ARP phase. It reloads trig_p from the shadow register only at its own wrap.

Pulse shaping:
- "Fire" starts a PULSE_CLKS-wide high pulse, beginning on the cycle after the firing tick edge (one-cycle latency from the tick).
- Because PULSE_CLKS < CLK_PER_US, every pulse returns low for at least 1 clock before the next one can fire.
- A fire during an active pulse cannot occur under the legal parameter range.

Simultaneous events:
- ARP, ACP and TRIG may assert on the same cycle; each is independent.
- ENABLE falling on a boundary tick: the stop wins and no new pulse starts.

Decomposition:
- radar_pkg holds: state encoding (IDLE = 0, RUN = 1), the CLK_PER_US default of 100, and a legal-configuration check function.
- Sub-module pulse_stretch, instantiated 3×: inputs clk, async reset, fire, clear; output a PULSE_CLKS-wide pulse. It takes PULSE_CLKS as a parameter.

Test Plan:
- Bench parameters: CLK_PER_US = 4, PULSE_CLKS = 2.
- Basic run: ARP_US = 20, ACP_CNT = 4, TRIG_US = 3, ENABLE raised → ARP, ACP and TRIG rise 1 clock after ENABLE is sampled; ARP period 80 clks; ACP at ticks 0, 5, 10, 15 (every 20 clks); TRIG every 12 clks; loopback into radar_statistics (CLK_PER_US-matched) gives ARP_US = 20, ACP_CNT = 4, TRIG_US = 3 and CALIBRATED = 1 after 3 rotations.
- Non-integer spacing: ARP_US = 10, ACP_CNT = 3 → ACP at ticks 0, 4, 7, then 10 (coincident with ARP); exactly 3 ACPs per rotation over 5 rotations. Second case: ACP_CNT = ARP_US = 8 → one ACP every tick.
- Illegal configuration: ACP_CNT = 11, ARP_US = 10, ENABLE = 1 → CFG_ERR = 1, RUNNING = 0, all outputs 0; correcting to ACP_CNT = 5 → RUN entered, CFG_ERR = 0.
- Mid-rotation change: ARP_US changed from 20 to 16 at tick 7 → current rotation still 20 ticks, the following rotations 16; ROT_CNT increments at each ARP.
- Abort: ENABLE dropped 1 clock into an ARP pulse → ARP = 0 next cycle and RUNNING = 0; S_AXIS_ARESET pulsed mid-RUN → all outputs 0 immediately, without waiting for a clock edge; ROT_CNT = 0.
